// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with per-tenure hold limit and turnaround gap between owners.
// Optional macro RR_GRANT_ARBITER_LOCK_EN adds a lock input that suppresses the hold-limit preempt.
module rr_grant_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_HOLD   = 8,
    parameter int GAP_CYCLES = 1,
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int HC_W  = $clog2(MAX_HOLD) + 1,
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
`ifdef RR_GRANT_ARBITER_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid,
    output logic               preempted,
    output logic [HC_W-1:0]    hold_count,
    output logic [1:0]         dbg_state
);

    // Handshake: req is a level held while wanted; grant follows one cycle after
    // the IDLE arbitration and drops one cycle after release or preempt.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(MAX_HOLD - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(NUM_REQ - 1);

    state_t               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [ID_W-1:0]      owner_q;
    logic [ID_W-1:0]      ptr_q;
    logic [HC_W-1:0]      hold_q;
    logic [GAP_W-1:0]     gap_q;
    logic                 preempted_q;

    logic [ID_W-1:0]      sel_d;
    logic                 found_d;
    logic [ID_W-1:0]      idx_v;
    logic                 lock_on;
    logic                 release_c;
    logic                 preempt_c;

`ifdef RR_GRANT_ARBITER_LOCK_EN
    assign lock_on = lock;
`else
    assign lock_on = 1'b0;
`endif

    // Scan downward in offset so the smallest offset from ptr is the last writer.
    always_comb begin
        sel_d   = '0;
        found_d = 1'b0;
        idx_v   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx_v = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (req[idx_v]) begin
                sel_d   = idx_v;
                found_d = 1'b1;
            end
        end
    end

    assign release_c = (state_q == S_GRANT) && !req[owner_q];
    assign preempt_c = (state_q == S_GRANT) && req[owner_q] &&
                       (hold_q == HOLD_LAST) && !lock_on;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            hold_q      <= '0;
            gap_q       <= '0;
            preempted_q <= 1'b0;
        end else begin
            preempted_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        state_q <= S_GRANT;
                        grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_d;
                        owner_q <= sel_d;
                        hold_q  <= '0;
                    end
                end
                S_GRANT: begin
                    if (release_c || preempt_c) begin
                        state_q     <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                        grant_q     <= '0;
                        owner_q     <= '0;
                        hold_q      <= '0;
                        gap_q       <= '0;
                        ptr_q       <= (owner_q == ID_LAST) ? '0 : owner_q + 1'b1;
                        preempted_q <= preempt_c;
                    end else if (hold_q != HOLD_LAST) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                        gap_q   <= '0;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_id    = owner_q;
    assign grant_valid = |grant_q;
    assign preempted   = preempted_q;
    assign hold_count  = hold_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed test-plan sequences then random traffic, all checked cycle by cycle
// against an owner/tenure/gap reference model.
module tb_rr_grant_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int MAX_HOLD   = 8;
    localparam int GAP_CYCLES = 1;
    localparam int ID_W       = 2;
    localparam int HC_W       = 4;

    logic               clk;
    logic               rst;
    logic [NUM_REQ-1:0] req;
    logic               lock_in;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_valid;
    logic               preempted;
    logic [HC_W-1:0]    hold_count;
    logic [1:0]         dbg_state;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: who owns the resource, for how long, and how many
    // turnaround cycles remain before the next arbitration.
    int m_owner    = -1;
    int m_hold     = 0;
    int m_ptr      = 0;
    int m_gap_left = 0;
    bit m_pre      = 1'b0;

    rr_grant_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .MAX_HOLD   (MAX_HOLD),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
`ifdef RR_GRANT_ARBITER_LOCK_EN
        .lock        (lock_in),
`endif
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .preempted   (preempted),
        .hold_count  (hold_count),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic end_tenure(input bit by_preempt);
        m_ptr      = (m_owner + 1) % NUM_REQ;
        m_owner    = -1;
        m_hold     = 0;
        m_gap_left = GAP_CYCLES;
        m_pre      = by_preempt;
    endtask

    task automatic model_step();
        bit lock_on;
`ifdef RR_GRANT_ARBITER_LOCK_EN
        lock_on = lock_in;
`else
        lock_on = 1'b0;
`endif
        m_pre = 1'b0;
        if (!rst) begin
            m_owner = -1; m_hold = 0; m_ptr = 0; m_gap_left = 0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) end_tenure(1'b0);
            else if (m_hold == MAX_HOLD - 1 && !lock_on) end_tenure(1'b1);
            else if (m_hold < MAX_HOLD - 1) m_hold++;
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % NUM_REQ]) begin
                    m_owner = (m_ptr + k) % NUM_REQ;
                    m_hold  = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [NUM_REQ-1:0] exp_grant;
        exp_grant = (m_owner >= 0) ? (NUM_REQ'(1) << m_owner) : '0;
        check_eq("grant", grant, exp_grant);
        check_eq("grant_valid", grant_valid, (m_owner >= 0));
        check_eq("preempted", preempted, m_pre);
        check_eq("hold_count", hold_count, m_hold);
        check_eq("onehot0", $onehot0(grant), 1);
        if (m_owner >= 0) check_eq("grant_id", grant_id, m_owner);
    endtask

    task automatic cycle(input logic [NUM_REQ-1:0] r, input logic l, input logic rs);
        req     = r;
        lock_in = l;
        rst     = rs;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic run(input logic [NUM_REQ-1:0] r, input int n);
        for (int i = 0; i < n; i++) cycle(r, 1'b0, 1'b1);
    endtask

    logic [NUM_REQ-1:0] rnd_req;
    int low_cnt;

    initial begin
        req = '0; lock_in = 1'b0; rst = 1'b0;

        // Reset state
        cycle('0, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        check_eq("reset_grant", grant, 0);
        check_eq("reset_hold", hold_count, 0);

        // Single requester 2: grant one cycle after request
        cycle(4'b0100, 1'b0, 1'b1);
        check_eq("first_grant", grant, 4'b0100);
        check_eq("first_id", grant_id, 2);
        run(4'b0100, 4);
        check_eq("hold_4", hold_count, 4);
        run(4'b0000, 4);

        // All requesting: round-robin order with preempts and 2 low cycles
        cycle('0, 1'b0, 1'b0);
        low_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            cycle(4'b1111, 1'b0, 1'b1);
            if (i == 0)  check_eq("rr_first", grant, 4'b0001);
            if (i == 10) check_eq("rr_second", grant, 4'b0010);
            if (i == 20) check_eq("rr_third", grant, 4'b0100);
            if (i == 30) check_eq("rr_fourth", grant, 4'b1000);
            if (i == 40) check_eq("rr_wrap", grant, 4'b0001);
            if (i == 8)  check_eq("rr_pre_pulse", preempted, 1);
            if (!grant_valid) low_cnt++;
        end
        check_eq("rr_low_cycles", low_cnt, 8);

        // Owner 1 releases early while 3 waits
        cycle('0, 1'b0, 1'b0);
        run(4'b1010, 3);
        run(4'b1000, 3);
        check_eq("release_next", grant, 4'b1000);
        run(4'b0000, 3);

        // Sole requester 0 re-granted after each preempt
        cycle('0, 1'b0, 1'b0);
        run(4'b0001, 30);
        run(4'b0000, 3);

        // Reset mid-tenure, then requester 0 wins first
        cycle('0, 1'b0, 1'b0);
        run(4'b0010, 6);
        check_eq("mid_hold", hold_count, 5);
        cycle(4'b0010, 1'b0, 1'b0);
        check_eq("mid_rst_grant", grant, 0);
        check_eq("mid_rst_hold", hold_count, 0);
        cycle(4'b0011, 1'b0, 1'b1);
        check_eq("post_rst_winner", grant, 4'b0001);
        run(4'b0000, 3);

`ifdef RR_GRANT_ARBITER_LOCK_EN
        // Locked owner 2 keeps the grant past the hold limit
        cycle('0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(4'b0100, 1'b1, 1'b1);
        check_eq("lock_hold_sat", hold_count, MAX_HOLD - 1);
        check_eq("lock_grant", grant, 4'b0100);
        cycle(4'b0000, 1'b1, 1'b1);
        check_eq("lock_release", grant, 0);
`endif

        // Random traffic with sticky requests and rare resets
        rnd_req = '0;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < NUM_REQ; b++)
                if ($urandom_range(0, 7) == 0) rnd_req[b] = ~rnd_req[b];
            cycle(rnd_req, 1'($urandom_range(0, 1)), ($urandom_range(0, 149) != 0));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among NUM_REQ requesters.
- Example resource: the command input of a state-machine-driven datapath.
- Built around a 3-state FSM (IDLE, GRANT, GAP) with a per-grant hold counter that enforces a maximum tenure, and a gap counter that inserts turnaround cycles between owners.
- Sits between requester blocks and the shared resource; its one-hot grant steers the resource's input mux.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- MAX_HOLD, 8, maximum consecutive grant cycles per tenure (>=1).
- GAP_CYCLES, 1, idle turnaround cycles after each tenure (>=0).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-low.
- req  input  NUM_REQ  per-requester request level; held high while the resource is wanted.
- grant  output  NUM_REQ  one-hot grant, registered.
- grant_id  output  max(1,clog2(NUM_REQ))  index of the current owner; valid only when grant_valid=1.
- grant_valid  output  1  high while any grant bit is high.
- preempted  output  1  one-cycle pulse in the first cycle after a tenure is ended by MAX_HOLD.
- hold_count  output  clog2(MAX_HOLD)+1  cycles the current owner has held the grant, starting at 0.

Behaviour:
- Reset: rst sampled low at posedge puts the block in this state on the next cycle, including mid-tenure:
  - state=IDLE; grant=0, grant_id=0, grant_valid=0, preempted=0, hold_count=0.
  - round-robin pointer ptr=0; gap counter=0.
  - No pending state survives reset.
- IDLE:
  - Each cycle, if req != 0, select the first set bit scanning from index ptr upward, wrapping at NUM_REQ.
  - Next cycle: state=GRANT, grant[sel]=1, grant_id=sel, hold_count=0.
  - If req == 0, stay in IDLE.
  - Request-to-grant latency is 1 cycle.
- GRANT, evaluated each cycle on the owner o:
  - release if req[o]==0;
  - preempt if req[o]==1 and hold_count==MAX_HOLD-1;
  - otherwise hold_count+1, grant unchanged.
  - On release or preempt:
    - next cycle grant=0, grant_valid=0, hold_count=0;
    - ptr=(o+1) mod NUM_REQ;
    - state=GAP if GAP_CYCLES>0, else IDLE.
  - preempted=1 for exactly the first cycle after a preempt.
  - If req[o] drops in the same cycle hold_count reaches MAX_HOLD-1, treat it as a release: preempted stays 0.
- GAP:
  - Gap counter counts 0..GAP_CYCLES-1 with grant=0.
  - Requests are ignored.
  - After the last gap cycle, state=IDLE.
- Continuous requests: grant is low for exactly GAP_CYCLES+1 cycles between tenures (the GAP cycles plus one IDLE arbitration cycle).
- Tenure length:
  - A tenure lasts 1..MAX_HOLD cycles.
  - With MAX_HOLD=1, every tenure ends by preempt unless req drops.
- Fairness:
  - A preempted requester that keeps req high ranks behind all other active requesters at the next arbitration.
  - If it is the sole requester, it is re-granted after GAP_CYCLES+1 low cycles.
- Requests from non-owners during GRANT or GAP have no effect until the next IDLE evaluation.
- grant is always one-hot or zero; grant_valid == |grant.
- Pointer wrap: an owner at NUM_REQ-1 sets ptr=0.

Optional Feature:
- Macro: RR_GRANT_ARBITER_LOCK_EN.
- With the macro defined:
  - Adds input port lock (1 bit), placed after req.
  - While the arbiter is in GRANT and lock=1, the MAX_HOLD preempt is suppressed.
  - hold_count saturates at MAX_HOLD-1 and does not wrap.
  - The tenure ends only when req[o] is released.
  - lock is ignored outside GRANT.
- Without the macro: no lock port; MAX_HOLD preemption is always enforced.

Test Plan:
- Defaults. After reset, req=4'b0100 at cycle 0 -> grant=4'b0100, grant_id=2 at cycle 1; grant_valid=1; hold_count counts 0,1,2...
- req=4'b1111 held constant -> grant order 0,1,2,3,0. Each tenure lasts 8 cycles with preempted pulsing once after it; grant is low for 2 cycles between tenures.
- Owner 1 drops req after 3 grant cycles while req[3]=1 -> grant low 2 cycles, then grant=4'b1000; preempted stays 0.
- Sole requester 0 held high for 30 cycles -> tenures of 8 cycles separated by 2 low cycles, re-granted to 0 each time; preempted pulses each time.
- rst low for one edge mid-tenure (grant=4'b0010, hold_count=5) -> next cycle all outputs 0 and ptr=0. With req=4'b0011 afterward, requester 0 wins first.
- With RR_GRANT_ARBITER_LOCK_EN, owner 2 holds req=1 and lock=1 for 20 cycles -> grant stays 4'b0100 for 20 cycles; hold_count saturates at 7; no preempted pulse; release occurs on req drop.
